// File: rtl/micro_sequencer_if.sv
// rtl/micro_sequencer_if.sv - control/microstore bus between IR/flags side and the micro_sequencer
interface micro_sequencer_if #(
  parameter int CW_W   = 32,
  parameter int CAR_W  = 8,
  parameter int OP_W   = 8,
  parameter int FSEL_W = 3
);
  localparam int FLAG_W = 1 << FSEL_W;
  localparam int UW     = 3 + FSEL_W + 1 + CAR_W + CW_W;

  logic              stall;
  logic              resume;
  logic [OP_W-1:0]   data_from_ir;
  logic [FLAG_W-1:0] flags;
  logic              uc_we;
  logic [CAR_W-1:0]  uc_addr;
  logic [UW-1:0]     uc_wdata;
  logic [CW_W-1:0]   control_signal;
  logic [CAR_W-1:0]  car_addr;
  logic              halted;
  logic              illegal_op;

  // Driver of opcode, flags and microstore writes; consumer of the control bus.
  modport master (
    output stall, resume, data_from_ir, flags, uc_we, uc_addr, uc_wdata,
    input  control_signal, car_addr, halted, illegal_op
  );

  // The sequencer itself.
  modport slave (
    input  stall, resume, data_from_ir, flags, uc_we, uc_addr, uc_wdata,
    output control_signal, car_addr, halted, illegal_op
  );
endinterface

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microprogrammed control unit with writable microstore and sequencer
module micro_sequencer #(
  parameter int CW_W    = 32,
  parameter int CAR_W   = 8,
  parameter int OP_W    = 8,
  parameter int FSEL_W  = 3,
  parameter int SLOT_W  = 3,
  parameter int NUM_OPS = 17
) (
  input logic                clk,
  input logic                rst,
  micro_sequencer_if.slave   bus
);
  localparam int UW    = 3 + FSEL_W + 1 + CAR_W + CW_W;
  localparam int DEPTH = 1 << CAR_W;
  localparam logic [OP_W:0] NUM_OPS_W = (OP_W + 1)'(NUM_OPS);

  typedef enum logic {ST_RUN, ST_HALT} state_t;
  typedef enum logic [2:0] {
    SEQ_INC   = 3'd0,
    SEQ_CLEAR = 3'd1,
    SEQ_MAP   = 3'd2,
    SEQ_BR    = 3'd3,
    SEQ_JUMP  = 3'd4,
    SEQ_HALT  = 3'd5
  } seq_t;

  logic [UW-1:0]     r_ustore [DEPTH];
  state_t            r_state, w_state_nxt;
  logic [CAR_W-1:0]  r_car, w_car_nxt;
  logic [CW_W-1:0]   r_ctrl, w_ctrl_nxt;
  logic              r_illegal, w_illegal_nxt;

  logic [UW-1:0]     w_uw;
  seq_t              w_seq;
  logic [FSEL_W-1:0] w_fsel;
  logic              w_fpol;
  logic [CAR_W-1:0]  w_target;
  logic [CW_W-1:0]   w_ctrl;
  logic [CAR_W-1:0]  w_car_inc;
  logic [CAR_W-1:0]  w_map;
  logic              w_op_bad;

  // Combinational microstore read; a same-edge write is not visible until next cycle.
  assign w_uw     = r_ustore[r_car];
  assign w_seq    = seq_t'(w_uw[UW-1 -: 3]);
  assign w_fsel   = w_uw[UW-4 -: FSEL_W];
  assign w_fpol   = w_uw[CAR_W + CW_W];
  assign w_target = w_uw[CW_W +: CAR_W];
  assign w_ctrl   = w_uw[CW_W-1:0];

  assign w_car_inc = r_car + {{(CAR_W-1){1'b0}}, 1'b1};
  assign w_map     = CAR_W'({bus.data_from_ir, {SLOT_W{1'b0}}});
  assign w_op_bad  = {1'b0, bus.data_from_ir} >= NUM_OPS_W;

  // Microstore load port: writes at any edge, untouched by reset, stall or halt.
  always_ff @(posedge clk) begin
    if (bus.uc_we) begin
      r_ustore[bus.uc_addr] <= bus.uc_wdata;
    end
  end

  // Next-state selection: stall freezes everything, halt waits for resume, else follow the microword.
  always_comb begin
    w_state_nxt   = r_state;
    w_car_nxt     = r_car;
    w_ctrl_nxt    = r_ctrl;
    w_illegal_nxt = 1'b0;
    if (bus.stall) begin
      w_illegal_nxt = 1'b0;
    end else if (r_state == ST_HALT) begin
      w_ctrl_nxt = '0;
      if (bus.resume) begin
        w_car_nxt   = '0;
        w_state_nxt = ST_RUN;
      end
    end else begin
      w_ctrl_nxt = w_ctrl;
      case (w_seq)
        SEQ_CLEAR: w_car_nxt = '0;
        SEQ_MAP: begin
          if (w_op_bad) begin
            w_car_nxt     = '0;
            w_illegal_nxt = 1'b1;
          end else begin
            w_car_nxt = w_map;
          end
        end
        SEQ_BR:    w_car_nxt = (bus.flags[w_fsel] == w_fpol) ? w_target : w_car_inc;
        SEQ_JUMP:  w_car_nxt = w_target;
        SEQ_HALT:  w_state_nxt = ST_HALT;
        default:   w_car_nxt = w_car_inc;
      endcase
    end
  end

  // Sequencer state register with asynchronous reset to the fetch entry point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_car     <= '0;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_car     <= w_car_nxt;
      r_ctrl    <= w_ctrl_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  assign bus.control_signal = r_ctrl;
  assign bus.car_addr       = r_car;
  assign bus.halted         = (r_state == ST_HALT);
  assign bus.illegal_op     = r_illegal;
endmodule
